// File: rtl/ifetch_pkg.sv
// Shared constants and types for the instruction-fetch front end.
package ifetch_pkg;

   localparam int          WORD_BYTES       = 4;
   localparam logic [31:0] PC_START_DEFAULT = 32'h0040_0020;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   function automatic int count_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch FIFO holding {pc, instr} entries; flush wins over push, head is read from storage registers.
module ifetch_fifo
   import ifetch_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CW    = count_width(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   input  logic          push,
   input  logic [31:0]   push_pc,
   input  logic [31:0]   push_instr,
   input  logic          pop,
   output logic [CW-1:0] count,
   output logic [31:0]   head_pc,
   output logic [31:0]   head_instr
);

   localparam int PW = $clog2(DEPTH);

   fetch_entry_t  mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic          do_push;
   logic          do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
      return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
   endfunction

   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count < CW'(DEPTH)) || do_pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         // A concurrent pop is subsumed by the flush; the pushed word is dropped.
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= '{pc: push_pc, instr: push_instr};
            wr_ptr      <= ptr_inc(wr_ptr);
         end
         if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Empty FIFO presents zeros so the outputs never expose stale entries.
   always_comb begin
      head_pc    = '0;
      head_instr = '0;
      if (count != '0) begin
         head_pc    = mem[rd_ptr].pc;
         head_instr = mem[rd_ptr].instr;
      end
   end

endmodule

// File: rtl/ifetch_prefetch.sv
// Fetch front end: owns the PC, issues sequential fetches, buffers returns in a prefetch FIFO.
// Optional macro IFETCH_ALIGN_CHECK_EN adds a sticky align_err output and word-aligns redirect targets.
module ifetch_prefetch
   import ifetch_pkg::*;
#(
   parameter logic [31:0] PC_START = PC_START_DEFAULT,
   parameter int          DEPTH    = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load_pc,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_rvalid,
`ifdef IFETCH_ALIGN_CHECK_EN
   output logic        align_err,
`endif
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc
);

   localparam int          CW      = count_width(DEPTH);
   localparam logic [31:0] PC_STEP = 32'(WORD_BYTES);

   logic [31:0]   pc;
   logic [31:0]   req_pc;
   logic          inflight;
   logic          discard;
   logic [CW-1:0] fifo_count;
   logic [CW:0]   credit_used;
   logic [31:0]   target_pc;
   logic          flush;
   logic          push;
   logic          pop;

`ifdef IFETCH_ALIGN_CHECK_EN
   assign target_pc = redirect_pc & ~32'h3;

   always_ff @(posedge clk) begin
      if (reset) align_err <= 1'b0;
      else if (redirect && (redirect_pc[1:0] != 2'b00)) align_err <= 1'b1;
   end
`else
   assign target_pc = redirect_pc;
`endif

   assign flush = load_pc || redirect;

   // Credit counts buffered entries plus the one outstanding fetch; a same-cycle pop earns nothing.
   assign credit_used = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
   assign imem_req    = !reset && !flush && (credit_used < (CW+1)'(DEPTH));
   assign imem_addr   = pc;

   // Output handshake: an entry transfers on a cycle where out_valid && out_ready; while
   // out_valid && !out_ready the head is held stable, and out_valid never depends on out_ready.
   assign out_valid = (fifo_count != '0);
   assign pop       = out_valid && out_ready;
   assign push      = imem_rvalid && inflight && !discard;

   always_ff @(posedge clk) begin
      if (reset) begin
         pc       <= PC_START;
         req_pc   <= '0;
         inflight <= 1'b0;
         discard  <= 1'b0;
      end else begin
         discard  <= flush && inflight;
         inflight <= imem_req;
         if (imem_req) req_pc <= pc;
         if (load_pc)       pc <= PC_START;
         else if (redirect) pc <= target_pc;
         else if (imem_req) pc <= pc + PC_STEP;
      end
   end

   ifetch_fifo #(
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .push       (push),
      .push_pc    (req_pc),
      .push_instr (imem_rdata),
      .pop        (pop),
      .count      (fifo_count),
      .head_pc    (out_pc),
      .head_instr (out_instr)
   );

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Directed bench for ifetch_prefetch; a memory model returns word = address one cycle after each request.
module tb_ifetch_prefetch;

   logic        clk = 1'b0;
   logic        reset;
   logic        load_pc;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = '0;
   logic        imem_rvalid = 1'b0;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        spur;
`ifdef IFETCH_ALIGN_CHECK_EN
   logic        align_err;
`endif

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   ifetch_prefetch dut (
      .clk         (clk),
      .reset       (reset),
      .load_pc     (load_pc),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .imem_rvalid (imem_rvalid),
`ifdef IFETCH_ALIGN_CHECK_EN
      .align_err   (align_err),
`endif
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_instr   (out_instr),
      .out_pc      (out_pc)
   );

   // Synchronous memory; spur injects a response that was never requested.
   always @(posedge clk) begin
      imem_rvalid <= imem_req | spur;
      imem_rdata  <= spur ? 32'hDEAD_BEEF : imem_addr;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(negedge clk);
   endtask

   initial begin
      reset       = 1'b1;
      load_pc     = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      out_ready   = 1'b1;
      spur        = 1'b0;
      repeat (3) next_cycle();

      // Reset state
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_req",   32'(imem_req),  32'd0);
      check("rst_pc",    out_pc,         32'h0);
      check("rst_instr", out_instr,      32'h0);

      // Streaming from reset, first out_valid in cycle 2
      reset = 1'b0;
      #1;
      check("c0_req",  32'(imem_req), 32'd1);
      check("c0_addr", imem_addr,     32'h0040_0020);
      next_cycle();
      check("c1_valid", 32'(out_valid), 32'd0);
      next_cycle();
      check("c2_valid", 32'(out_valid), 32'd1);
      check("c2_pc",    out_pc,         32'h0040_0020);
      check("c2_instr", out_instr,      32'h0040_0020);
      next_cycle();
      check("c3_pc", out_pc, 32'h0040_0024);
      next_cycle();
      check("c4_pc",   out_pc,    32'h0040_0028);
      check("c4_addr", imem_addr, 32'h0040_0030);

      // Redirect while 0040002C is in flight
      redirect    = 1'b1;
      redirect_pc = 32'h0040_0100;
      #1;
      check("redir_req_off", 32'(imem_req), 32'd0);
      next_cycle();
      redirect = 1'b0;
      #1;
      check("redir_t1_valid", 32'(out_valid), 32'd0);
      check("redir_t1_req",   32'(imem_req),  32'd1);
      check("redir_t1_addr",  imem_addr,      32'h0040_0100);
      next_cycle();
      check("redir_t2_valid", 32'(out_valid), 32'd0);
      next_cycle();
      check("redir_t3_valid", 32'(out_valid), 32'd1);
      check("redir_t3_pc",    out_pc,         32'h0040_0100);
      next_cycle();
      check("redir_t4_pc", out_pc, 32'h0040_0104);

      // load_pc beats a simultaneous redirect
      load_pc     = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'h0050_0000;
      #1;
      check("load_req_off", 32'(imem_req), 32'd0);
      next_cycle();
      load_pc  = 1'b0;
      redirect = 1'b0;
      #1;
      check("load_t1_addr",  imem_addr,      32'h0040_0020);
      check("load_t1_valid", 32'(out_valid), 32'd0);
      next_cycle();
      next_cycle();
      check("load_t3_valid", 32'(out_valid), 32'd1);
      check("load_t3_pc",    out_pc,         32'h0040_0020);

      // Backpressure from reset: exactly DEPTH entries, then ordered drain
      out_ready = 1'b0;
      reset     = 1'b1;
      next_cycle();
      reset = 1'b0;
      repeat (5) next_cycle();
      check("bp_c5_pc",  out_pc,         32'h0040_0020);
      check("bp_c5_req", 32'(imem_req),  32'd0);
      repeat (5) next_cycle();
      check("bp_c10_valid", 32'(out_valid), 32'd1);
      check("bp_c10_pc",    out_pc,         32'h0040_0020);
      check("bp_c10_req",   32'(imem_req),  32'd0);
      check("bp_c10_addr",  imem_addr,      32'h0040_0030);
      for (int k = 0; k < 6; k++) exp_q.push_back(32'h0040_0020 + 32'(4 * k));
      for (int i = 0; i < 6; i++) begin
         check("drain_valid", 32'(out_valid), 32'd1);
         check("drain_pc",    out_pc,         exp_q.pop_front());
         if (i == 1) begin
            check("resume_req",  32'(imem_req), 32'd1);
            check("resume_addr", imem_addr,     32'h0040_0030);
         end
         out_ready = 1'b1;
         next_cycle();
      end

      // PC wraps modulo 2^32
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFF8;
      next_cycle();
      redirect = 1'b0;
      #1;
      check("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
      next_cycle();
      check("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
      next_cycle();
      check("wrap_addr2", imem_addr, 32'h0000_0000);
      check("wrap_pc0",   out_pc,    32'hFFFF_FFF8);
      next_cycle();
      check("wrap_pc1", out_pc, 32'hFFFF_FFFC);
      next_cycle();
      check("wrap_valid2", 32'(out_valid), 32'd1);
      check("wrap_pc2",    out_pc,         32'h0000_0000);

      // Back-to-back redirects, last wins
      redirect    = 1'b1;
      redirect_pc = 32'h0040_0200;
      next_cycle();
      redirect_pc = 32'h0040_0300;
      #1;
      check("b2b_req_off", 32'(imem_req), 32'd0);
      next_cycle();
      redirect = 1'b0;
      #1;
      check("b2b_addr",  imem_addr,      32'h0040_0300);
      check("b2b_valid", 32'(out_valid), 32'd0);
      next_cycle();
      next_cycle();
      check("b2b_out_valid", 32'(out_valid), 32'd1);
      check("b2b_out_pc",    out_pc,         32'h0040_0300);

      // Reset mid-stream with an unrequested response right after it
      reset = 1'b1;
      spur  = 1'b1;
      next_cycle();
      reset = 1'b0;
      spur  = 1'b0;
      next_cycle();
      check("spur_valid", 32'(out_valid), 32'd0);
      next_cycle();
      check("post_rst_valid", 32'(out_valid), 32'd1);
      check("post_rst_pc",    out_pc,         32'h0040_0020);
      check("post_rst_instr", out_instr,      32'h0040_0020);

`ifdef IFETCH_ALIGN_CHECK_EN
      // Misaligned redirect target is word-aligned and flagged sticky
      check("align_init", 32'(align_err), 32'd0);
      redirect    = 1'b1;
      redirect_pc = 32'h0040_0102;
      next_cycle();
      redirect = 1'b0;
      #1;
      check("align_set",  32'(align_err), 32'd1);
      check("align_addr", imem_addr,      32'h0040_0100);
      next_cycle();
      next_cycle();
      check("align_pc", out_pc, 32'h0040_0100);
      repeat (3) next_cycle();
      check("align_sticky", 32'(align_err), 32'd1);
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
      check("align_clr", 32'(align_err), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
